// File: rtl/bitserial_mac_ctrl.sv
// bitserial_mac_ctrl -- weight bit-column sequencer for a bit-serial MAC (LSB first, overlapped tiles).
// Optional macro BITSERIAL_ZERO_COL_SKIP_EN: skip columns whose col_nz_mask bit is clear.
`default_nettype none

module bitserial_mac_ctrl #(
  parameter int MAX_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] prec,
  input  logic [7:0] col_nz_mask,
  input  logic       stall,
  output logic       start_ready,
  output logic       en,
  output logic       load_accum,
  output logic [2:0] column_idx,
  output logic       is_msb,
  output logic       w_rd_en,
  output logic       busy,
  output logic       out_valid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state, state_n;
  logic [2:0] col, col_n;
  logic [2:0] prec_l, prec_l_n;
  logic [7:0] mask_l, mask_l_n;
  logic       first, first_n;
  logic       chained, chained_n;
  logic       load_pend, load_pend_n;
  logic       ov_pend, ov_pend_n;

  logic [2:0] prec_in;
  logic [7:0] cols_in;
  logic [7:0] cols_l;
  logic [7:0] rem;
  logic       last_col;
  logic       accept;

  function automatic logic [7:0] col_limit(input logic [2:0] p);
    for (int i = 0; i < 8; i++) col_limit[i] = (i <= int'(p));
  endfunction

  function automatic logic [2:0] lowest(input logic [7:0] m);
    lowest = 3'd0;
    for (int i = 7; i >= 0; i--) if (m[i]) lowest = 3'(i);
  endfunction

  assign prec_in = (int'(prec) >= MAX_BITS) ? 3'(MAX_BITS - 1) : prec;

`ifdef BITSERIAL_ZERO_COL_SKIP_EN
  assign cols_in = col_limit(prec_in) & col_nz_mask;
  assign cols_l  = col_limit(prec_l) & mask_l;
`else
  logic unused_mask;
  assign unused_mask = ^mask_l;
  assign cols_in = col_limit(prec_in);
  assign cols_l  = col_limit(prec_l);
`endif

  // Columns still to be issued after the current one; empty means this is the last.
  assign rem      = cols_l & (8'hFF << (4'(col) + 4'd1));
  assign last_col = (rem == 8'd0);

  assign start_ready = !stall && ((state == IDLE) || (state == DRAIN) ||
                                  ((state == ISSUE) && last_col));
  assign accept      = start && start_ready;
  assign busy        = (state != IDLE);
  assign load_accum  = load_pend && !stall;
  assign out_valid   = ov_pend && !stall;

  always_comb begin
    state_n     = state;
    col_n       = col;
    prec_l_n    = prec_l;
    mask_l_n    = mask_l;
    first_n     = first;
    chained_n   = chained;
    load_pend_n = load_pend;
    ov_pend_n   = ov_pend;
    en          = 1'b0;
    w_rd_en     = 1'b0;
    column_idx  = 3'd0;
    is_msb      = 1'b0;

    case (state)
      ISSUE: begin
        en         = !stall;
        w_rd_en    = !stall;
        column_idx = col;
        is_msb     = (col == prec_l);
      end
      DRAIN:   en = !stall;
      default: ;
    endcase

    if (!stall) begin
      load_pend_n = (state == ISSUE) && first;
      // The next tile's first issue cycle stands in for the drain of a chained tile.
      ov_pend_n   = (state == DRAIN) || ((state == ISSUE) && first && chained);
      first_n     = 1'b0;
      case (state)
        IDLE: if (accept) state_n = ISSUE;
        ISSUE: begin
          if (!last_col) begin
            col_n = lowest(rem);
          end else if (!accept) begin
            state_n = DRAIN;
            col_n   = 3'd0;
          end
        end
        DRAIN: state_n = accept ? ISSUE : IDLE;
        default: state_n = IDLE;
      endcase
      if (accept) begin
        col_n     = lowest(cols_in);
        prec_l_n  = prec_in;
        mask_l_n  = col_nz_mask;
        first_n   = 1'b1;
        chained_n = (state == ISSUE);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      col       <= 3'd0;
      prec_l    <= 3'd0;
      mask_l    <= 8'd0;
      first     <= 1'b0;
      chained   <= 1'b0;
      load_pend <= 1'b0;
      ov_pend   <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      prec_l    <= prec_l_n;
      mask_l    <= mask_l_n;
      first     <= first_n;
      chained   <= chained_n;
      load_pend <= load_pend_n;
      ov_pend   <= ov_pend_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bitserial_mac_ctrl.sv
// tb_bitserial_mac_ctrl -- directed and random checks against a time-slot schedule model.
`default_nettype none

module tb_bitserial_mac_ctrl;

  localparam int MB = 8;
  localparam int N  = 4096;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] prec = 3'd0;
  logic [7:0] col_nz_mask = 8'd0;
  logic       stall = 1'b0;
  logic       start_ready, en, load_accum, is_msb, w_rd_en, busy, out_valid;
  logic [2:0] column_idx;

  bitserial_mac_ctrl #(.MAX_BITS(MB)) dut (
    .clk(clk), .reset(reset), .start(start), .prec(prec), .col_nz_mask(col_nz_mask),
    .stall(stall), .start_ready(start_ready), .en(en), .load_accum(load_accum),
    .column_idx(column_idx), .is_msb(is_msb), .w_rd_en(w_rd_en), .busy(busy),
    .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // Expected behaviour per unstalled time slot.
  bit         iss[N], lst[N], drn[N], lda[N], ovl[N], msb[N];
  logic [2:0] cl[N];
  int         t = 0;
  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  int         start_cyc = 0;
  int         ov_cyc = 0;
  bit         both_seen = 0;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      iss[i] = 0; lst[i] = 0; drn[i] = 0; lda[i] = 0; ovl[i] = 0; msb[i] = 0; cl[i] = 3'd0;
    end
    t = 0;
  endtask

  task automatic sched(input int t0, input logic [2:0] p, input logic [7:0] m);
    int pe;
    int n;
    int cols[$];
    pe = (int'(p) >= MB) ? MB - 1 : int'(p);
`ifdef BITSERIAL_ZERO_COL_SKIP_EN
    for (int c = 0; c <= pe; c++) if (m[c]) cols.push_back(c);
`else
    begin
      bit unused_m;
      unused_m = ^m;
    end
    for (int c = 0; c <= pe; c++) cols.push_back(c);
`endif
    if (cols.size() == 0) cols.push_back(0);
    n = cols.size();
    for (int k = 0; k < n; k++) begin
      iss[t0 + 1 + k] = 1;
      cl[t0 + 1 + k]  = 3'(cols[k]);
      msb[t0 + 1 + k] = (cols[k] == pe);
    end
    lst[t0 + n]     = 1;
    drn[t0 + 1]     = 0;
    drn[t0 + n + 1] = 1;
    lda[t0 + 2]     = 1;
    ovl[t0 + n + 2] = 1;
  endtask

  task automatic step(input bit st, input bit sv, input logic [2:0] p, input logic [7:0] m);
    bit rdy;
    @(negedge clk);
    start = st; stall = sv; prec = p; col_nz_mask = m;
    #1;
    rdy = !sv && !(iss[t] && !lst[t]);
    check("start_ready", start_ready, rdy);
    check("busy", busy, iss[t] || drn[t]);
    check("en", en, !sv && (iss[t] || drn[t]));
    check("w_rd_en", w_rd_en, !sv && iss[t]);
    check("column_idx", column_idx, iss[t] ? cl[t] : 3'd0);
    check("is_msb", is_msb, iss[t] && msb[t]);
    check("load_accum", load_accum, !sv && lda[t]);
    check("out_valid", out_valid, !sv && ovl[t]);
    if (out_valid) ov_cyc = cyc;
    if (out_valid && load_accum) both_seen = 1;
    if (!sv) begin
      if (st && rdy) begin
        sched(t, p, m);
        start_cyc = cyc;
      end
      t++;
    end
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    start = 0; stall = 0;
    reset = 1;
    #1;
    check("rst_ready", start_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_en", en, 1'b0);
    check("rst_col", column_idx, 3'd0);
    check("rst_outs", {w_rd_en, is_msb, load_accum, out_valid}, 4'b0);
    clear_model();
    #1 reset = 0;
    cyc++;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 3'd0, 8'd0);
  endtask

  initial begin
    clear_model();
    do_reset();

    // Single prec=7 tile: out_valid 10 cycles after the accepted start.
    step(1, 0, 3'd7, 8'hFF);
    idle(12);
    check("lat_p7", 8'(ov_cyc - start_cyc), 8'd10);

    // Two back-to-back prec=3 tiles.
    both_seen = 0;
    step(1, 0, 3'd3, 8'hFF);
    idle(3);
    step(1, 0, 3'd3, 8'hFF);
    idle(8);
    check("b2b_overlap", both_seen, 1'b1);

    // Stall for three cycles while column 4 is presented.
    step(1, 0, 3'd7, 8'hFF);
    idle(4);
    for (int i = 0; i < 3; i++) step(0, 1, 3'd0, 8'd0);
    idle(10);
    check("lat_stall", 8'(ov_cyc - start_cyc), 8'd13);

    // Reset while column 5 is presented, then restart.
    step(1, 0, 3'd7, 8'hFF);
    idle(5);
    do_reset();
    step(1, 0, 3'd2, 8'hFF);
    idle(6);
    check("lat_after_rst", 8'(ov_cyc - start_cyc), 8'd5);

`ifdef BITSERIAL_ZERO_COL_SKIP_EN
    step(1, 0, 3'd7, 8'b1000_0101);
    idle(7);
    check("lat_skip", 8'(ov_cyc - start_cyc), 8'd5);
    step(1, 0, 3'd7, 8'h00);
    idle(5);
    check("lat_zero", 8'(ov_cyc - start_cyc), 8'd3);
`endif

    for (int i = 0; i < 900; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0), 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
      end
    end
    idle(12);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
